// File: rtl/tt_scan_pkg.sv
// ---------------------------------------------------------------------------
// tt_scan_pkg
// Shared definitions for the truth-table scan controller:
//   state_t   - FSM state encoding (IDLE, SETTLE, SAMPLE, DONE)
//   SETTLE_W  - width of the settle counter (settle intervals 1..15)
// ---------------------------------------------------------------------------
package tt_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int SETTLE_W = 4;

endpackage

// File: rtl/tt_settle_timer.sv
// ---------------------------------------------------------------------------
// tt_settle_timer
// Down-counter that measures how long a select value is held before sampling.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   i_load      - load i_load_val (has priority over i_dec)
//   i_load_val  - reload value (settle interval minus one)
//   i_dec       - decrement by one; stops at zero
//   o_zero      - counter is zero
// ---------------------------------------------------------------------------
module tt_settle_timer
  import tt_scan_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic [SETTLE_W-1:0] i_load_val,
  input  logic                i_dec,
  output logic                o_zero
);

  logic [SETTLE_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - SETTLE_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/tt_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tt_scan_ctrl
// Steps an external mux select through 0..N-1, waits SETTLE cycles on each
// value, samples the mux output f into a truth table and compares it with an
// expected table.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   start         - scan request, honoured in IDLE only
//   abort         - cancel a running scan (SETTLE/SAMPLE)
//   expected[N]   - expected f per select index
//   f             - mux output for the current sel
//   sel           - select driven to the datapath mux
//   busy          - high while in SETTLE or SAMPLE
//   done          - one-cycle pulse at scan completion
//   table_out[N]  - captured truth table
//   mismatch_cnt  - number of indices with f != expected
//   match         - mismatch_cnt==0, valid together with done
// ---------------------------------------------------------------------------
module tt_scan_ctrl
  import tt_scan_pkg::*;
#(
  parameter int SEL_W  = 3,
  parameter int SETTLE = 1,
  localparam int N     = 1 << SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [N-1:0]     expected,
  input  logic             f,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     table_out,
  output logic [SEL_W:0]   mismatch_cnt,
  output logic             match
);

  state_t r_state;
  state_t w_state_next;

  logic [SEL_W-1:0] r_sel;
  logic [N-1:0]     r_table;
  logic [SEL_W:0]   r_mism;
  logic             r_match;
  logic             r_busy;
  logic             r_done;

  logic             w_load;
  logic             w_dec;
  logic             w_zero;
  logic             w_clear;
  logic             w_sample;
  logic             w_sel_inc;
  logic             w_abort_go;
  logic             w_last;
  logic             w_miss;
  logic [SEL_W:0]   w_mism_next;

  tt_settle_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (SETTLE_W'(SETTLE - 1)),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  assign w_miss      = (f != expected[r_sel]);
  // Count including the sample taken this cycle, so match can be set on the
  // same edge that enters DONE.
  assign w_mism_next = r_mism + {{SEL_W{1'b0}}, w_miss};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_dec        = 1'b0;
    w_clear      = 1'b0;
    w_sample     = 1'b0;
    w_sel_inc    = 1'b0;
    w_abort_go   = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_SETTLE;
          w_load       = 1'b1;
          w_clear      = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          w_state_next = ST_IDLE;
          w_abort_go   = 1'b1;
        end else if (w_zero) begin
          w_state_next = ST_SAMPLE;
        end else begin
          w_dec = 1'b1;
        end
      end
      ST_SAMPLE: begin
        // abort wins over the sample update
        if (abort) begin
          w_state_next = ST_IDLE;
          w_abort_go   = 1'b1;
        end else begin
          w_sample = 1'b1;
          if (r_sel == SEL_W'(N - 1)) begin
            w_state_next = ST_DONE;
            w_last       = 1'b1;
          end else begin
            w_state_next = ST_SETTLE;
            w_sel_inc    = 1'b1;
            w_load       = 1'b1;
          end
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel   <= '0;
      r_table <= '0;
      r_mism  <= '0;
      r_match <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_busy <= (w_state_next == ST_SETTLE) || (w_state_next == ST_SAMPLE);
      r_done <= (w_state_next == ST_DONE);
      if (w_clear) begin
        r_sel   <= '0;
        r_table <= '0;
        r_mism  <= '0;
        r_match <= 1'b0;
      end else if (w_abort_go) begin
        r_sel <= '0;
      end else if (w_sample) begin
        r_table[r_sel] <= f;
        r_mism         <= w_mism_next;
        if (w_last) begin
          r_match <= (w_mism_next == '0);
        end
        if (w_sel_inc) begin
          r_sel <= r_sel + SEL_W'(1);
        end
      end
    end
  end

  assign sel          = r_sel;
  assign busy         = r_busy;
  assign done         = r_done;
  assign table_out    = r_table;
  assign mismatch_cnt = r_mism;
  assign match        = r_match;

endmodule

// File: tb/tb_tt_scan_ctrl.sv
module tb_tt_scan_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT0: default SETTLE=1, DUT1: SETTLE=3
  logic       start0 = 1'b0, abort0 = 1'b0, start1 = 1'b0, abort1 = 1'b0;
  logic [7:0] data0 = '0, exp0 = '0, data1 = '0, exp1 = '0;
  logic       f0, f1;
  logic [2:0] sel0, sel1;
  logic       busy0, busy1, done0, done1, match0, match1;
  logic [7:0] tbl0, tbl1;
  logic [3:0] mism0, mism1;

  // mux8 datapath model: f = data[sel]
  assign f0 = data0[sel0];
  assign f1 = data1[sel1];

  tt_scan_ctrl dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0), .expected(exp0), .f(f0),
    .sel(sel0), .busy(busy0), .done(done0), .table_out(tbl0),
    .mismatch_cnt(mism0), .match(match0)
  );

  tt_scan_ctrl #(.SEL_W(3), .SETTLE(3)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .expected(exp1), .f(f1),
    .sel(sel1), .busy(busy1), .done(done1), .table_out(tbl1),
    .mismatch_cnt(mism1), .match(match1)
  );

  typedef struct {
    logic [7:0] tbl;
    logic [3:0] mism;
    logic       m;
    int         dc;   // cycle count at which done must be observed
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic push0(input logic [7:0] t, input logic [3:0] m, input logic mt, input int dc);
    exp_t e;
    e.tbl = t; e.mism = m; e.m = mt; e.dc = dc;
    q0.push_back(e);
  endtask

  task automatic push1(input logic [7:0] t, input logic [3:0] m, input logic mt, input int dc);
    exp_t e;
    e.tbl = t; e.mism = m; e.m = mt; e.dc = dc;
    q1.push_back(e);
  endtask

  // Scoreboard monitors: pop an expectation whenever done is presented
  always @(negedge clk) begin
    if (!rst && done0) begin
      if (q0.size() == 0) begin
        chk("dut0_unexpected_done", 32'(done0), 32'd0);
      end else begin
        e0 = q0.pop_front();
        chk("dut0_done_cycle", 32'(cyc), 32'(e0.dc));
        chk("dut0_table", 32'(tbl0), 32'(e0.tbl));
        chk("dut0_mismatch", 32'(mism0), 32'(e0.mism));
        chk("dut0_match", 32'(match0), 32'(e0.m));
        chk("dut0_sel_at_done", 32'(sel0), 32'd7);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done1) begin
      if (q1.size() == 0) begin
        chk("dut1_unexpected_done", 32'(done1), 32'd0);
      end else begin
        e1 = q1.pop_front();
        chk("dut1_done_cycle", 32'(cyc), 32'(e1.dc));
        chk("dut1_table", 32'(tbl1), 32'(e1.tbl));
        chk("dut1_mismatch", 32'(mism1), 32'(e1.mism));
        chk("dut1_match", 32'(match1), 32'(e1.m));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    // reset state
    #12;
    chk("rst_sel", 32'(sel0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_table", 32'(tbl0), 32'd0);
    chk("rst_mismatch", 32'(mism0), 32'd0);
    chk("rst_match", 32'(match0), 32'd0);
    @(negedge clk) rst = 1'b0;

    // 1: A5 vs A5, done after edge 16
    data0 = 8'hA5; exp0 = 8'hA5;
    @(negedge clk) start0 = 1'b1; e = cyc + 1; push0(8'hA5, 4'd0, 1'b1, e + 16);
    @(negedge clk) start0 = 1'b0;
    repeat (20) @(negedge clk);

    // 2: FF vs 00 -> 8 mismatches; monitor flags any second done
    data0 = 8'hFF; exp0 = 8'h00;
    @(negedge clk) start0 = 1'b1; e = cyc + 1; push0(8'hFF, 4'd8, 1'b0, e + 16);
    @(negedge clk) start0 = 1'b0;
    repeat (24) @(negedge clk);

    // 3: start held -> back-to-back scans every 18 cycles
    data0 = 8'h3C; exp0 = 8'h3C;
    @(negedge clk) start0 = 1'b1; e = cyc + 1;
    push0(8'h3C, 4'd0, 1'b1, e + 16);
    push0(8'h3C, 4'd0, 1'b1, e + 34);
    push0(8'h3C, 4'd0, 1'b1, e + 52);
    repeat (19) @(negedge clk);   // just after restart edge e+18
    chk("restart_table_cleared", 32'(tbl0), 32'd0);
    chk("restart_match_cleared", 32'(match0), 32'd0);
    chk("restart_busy", 32'(busy0), 32'd1);
    repeat (18) @(negedge clk);   // third scan accepted at e+36
    start0 = 1'b0;
    repeat (22) @(negedge clk);

    // 4: abort seen at edge e+6 while sampling sel=2
    data0 = 8'hFF; exp0 = 8'hFF;
    @(negedge clk) start0 = 1'b1; e = cyc + 1;
    @(negedge clk) start0 = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_busy_before", 32'(busy0), 32'd1);
    chk("abort_sel_before", 32'(sel0), 32'd2);
    abort0 = 1'b1;
    @(negedge clk) abort0 = 1'b0;
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_sel", 32'(sel0), 32'd0);
    chk("abort_table", 32'(tbl0), 32'h03);
    chk("abort_mismatch", 32'(mism0), 32'd0);
    chk("abort_match", 32'(match0), 32'd0);
    chk("abort_done", 32'(done0), 32'd0);
    repeat (20) @(negedge clk);

    // 5: async reset mid-scan, then a fresh scan
    data0 = 8'h5A; exp0 = 8'h5B;
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mrst_sel", 32'(sel0), 32'd0);
    chk("mrst_busy", 32'(busy0), 32'd0);
    chk("mrst_table", 32'(tbl0), 32'd0);
    chk("mrst_mismatch", 32'(mism0), 32'd0);
    chk("mrst_done", 32'(done0), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk) start0 = 1'b1; e = cyc + 1; push0(8'h5A, 4'd1, 1'b0, e + 16);
    @(negedge clk) start0 = 1'b0;
    repeat (20) @(negedge clk);

    // 6: SETTLE=3 instance, each sel held 4 cycles, done after edge 32
    data1 = 8'h96; exp1 = 8'h96;
    @(negedge clk) start1 = 1'b1; e = cyc + 1; push1(8'h96, 4'd0, 1'b1, e + 32);
    @(negedge clk) start1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      while (cyc < e + 4 * k + 3) @(negedge clk);
      chk($sformatf("settle3_sel_k%0d", k), 32'(sel1), 32'(k));
    end
    repeat (8) @(negedge clk);

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
